// File: rtl/ui_timing_pkg.sv
// Timing helpers and state encoding shared by the button input conditioners and the LED
// pulse stretcher, so both sides derive their cycle counts the same way.
package ui_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/event_pulse_stretcher.sv
// Stretches single-cycle event ticks into LED pulses with a guaranteed ON time and OFF gap;
// ticks arriving mid-pulse are queued in a saturating counter and replayed one pulse each.
module event_pulse_stretcher
  import ui_timing_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int ON_TIME_MS  = 100,
  parameter int OFF_TIME_MS = 100,
  parameter int MAX_PENDING = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               event_in,
  input  logic                               clear_ovf,
  output logic                               led_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int ON_CYCLES  = ms_to_cycles(CLK_FREQ, ON_TIME_MS);
  localparam int OFF_CYCLES = ms_to_cycles(CLK_FREQ, OFF_TIME_MS);
  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam int PEND_W     = $clog2(MAX_PENDING + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

  if (ON_CYCLES < 1) begin : g_on_check
    $error("event_pulse_stretcher: ON_CYCLES must be >= 1");
  end
  if (OFF_CYCLES < 1) begin : g_off_check
    $error("event_pulse_stretcher: OFF_CYCLES must be >= 1");
  end
  if (MAX_PENDING < 1) begin : g_pend_check
    $error("event_pulse_stretcher: MAX_PENDING must be >= 1");
  end

  stretch_state_t       state, next_state;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [PEND_W-1:0]    pending_next;
  logic                 overflow_next;
  logic                 accept;
  logic                 dequeue;
  logic                 ovf_set;

  // Timer holds "cycles left minus one" so the phase ends on the edge where it reads zero.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    next_state    = state;
    timer_next    = timer;
    pending_next  = pending;
    overflow_next = overflow;
    dequeue       = 1'b0;
    ovf_set       = 1'b0;
    accept        = event_in && (state != IDLE);

    case (state)
      IDLE: begin
        if (event_in) begin
          next_state = ON;
          timer_next = ON_LOAD;
        end
      end
      ON: begin
        if (timer == '0) begin
          next_state = GAP;
          timer_next = OFF_LOAD;
        end else begin
          timer_next = timer - TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          if (pending != '0) begin
            next_state = ON;
            timer_next = ON_LOAD;
            dequeue    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          timer_next = timer - TIMER_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        timer_next = '0;
      end
    endcase

    // A tick on the dequeue edge replaces the slot being consumed, so it cannot overflow.
    if (accept && !dequeue) begin
      if (pending == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pending_next = pending + PEND_W'(1);
      end
    end else if (dequeue && !accept) begin
      pending_next = pending - PEND_W'(1);
    end

    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (clear_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= 1'b0;
    end else begin
      state    <= next_state;
      timer    <= timer_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      led_out  <= (next_state == ON);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Self-checking bench: directed scenarios plus a pulse scoreboard that measures every LED
// pulse and gap against the expected pulse queue.
module tb_event_pulse_stretcher;

  localparam int CLK_FREQ    = 10_000;
  localparam int ON_TIME_MS  = 2;
  localparam int OFF_TIME_MS = 1;
  localparam int MAX_PEND    = 3;
  localparam int ON_CYC      = 20;
  localparam int OFF_CYC     = 10;
  localparam int PW          = $clog2(MAX_PEND + 1);

  logic          clk;
  logic          rst_n;
  logic          event_in;
  logic          clear_ovf;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_q[$];

  event_pulse_stretcher #(
    .CLK_FREQ    (CLK_FREQ),
    .ON_TIME_MS  (ON_TIME_MS),
    .OFF_TIME_MS (OFF_TIME_MS),
    .MAX_PENDING (MAX_PEND)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .event_in  (event_in),
    .clear_ovf (clear_ovf),
    .led_out   (led_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Pulse monitor: measures ON length and OFF gap of every pulse, popping expected lengths.
  initial begin
    int hi_cnt;
    int gap_cnt;
    int exp_len;
    logic prev_led;
    hi_cnt   = 0;
    gap_cnt  = 0;
    prev_led = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi_cnt   = 0;
        gap_cnt  = 0;
        prev_led = 1'b0;
      end else begin
        if (led_out) begin
          hi_cnt++;
        end else if (prev_led) begin
          checks_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL pulse_unexpected: got pulse of %0d cycles, want no pulse", hi_cnt);
          end else begin
            exp_len = exp_q.pop_front();
            if (hi_cnt !== exp_len)
              $display("FAIL pulse_len: got %0d cycles, want %0d", hi_cnt, exp_len);
            else
              checks_passed++;
          end
          hi_cnt = 0;
        end
        if (!led_out && busy) begin
          gap_cnt++;
        end else if (gap_cnt != 0) begin
          checks_total++;
          if (gap_cnt !== OFF_CYC)
            $display("FAIL gap_len: got %0d cycles, want %0d", gap_cnt, OFF_CYC);
          else
            checks_passed++;
          gap_cnt = 0;
        end
        prev_led = led_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_led(input logic val, input string name);
    int n = 0;
    while (led_out !== val && n < 200) begin
      tick();
      n++;
    end
    if (led_out !== val) begin
      checks_total++;
      $display("FAIL %s: led_out=%b after 200 cycles, want %b", name, led_out, val);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    checks_total++;
    if (busy !== 1'b0)
      $display("FAIL %s_idle: busy=%b after 1000 cycles, want 0", name, busy);
    else
      checks_passed++;
    @(negedge clk);
    #1;
    checks_total++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_pulses: %0d expected pulses never seen, want 0", name, exp_q.size());
    else
      checks_passed++;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    event_in  = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) tick();
    checks_total++;
    if ({led_out, busy, pending, overflow} !== '0)
      $display("FAIL reset_outputs: led=%b busy=%b pending=%0d ovf=%b, want all 0",
               led_out, busy, pending, overflow);
    else
      checks_passed++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    for (int i = 0; i < ON_CYC; i++) begin
      checks_total++;
      if (led_out !== 1'b1 || busy !== 1'b1 || pending !== '0)
        $display("FAIL single_on cyc %0d: led=%b busy=%b pending=%0d, want 1 1 0",
                 i, led_out, busy, pending);
      else
        checks_passed++;
      if (i < ON_CYC - 1) tick();
    end
    for (int i = 0; i < OFF_CYC; i++) begin
      tick();
      checks_total++;
      if (led_out !== 1'b0 || busy !== 1'b1 || pending !== '0)
        $display("FAIL single_gap cyc %0d: led=%b busy=%b pending=%0d, want 0 1 0",
                 i, led_out, busy, pending);
      else
        checks_passed++;
    end
    tick();
    checks_total++;
    if (busy !== 1'b0 || led_out !== 1'b0)
      $display("FAIL single_idle: busy=%b led=%b, want 0 0", busy, led_out);
    else
      checks_passed++;
    wait_idle("single");
  endtask

  task automatic test_queue();
    int exp_p[3] = '{2, 1, 0};
    for (int i = 0; i < 4; i++) exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks_total++;
      if (pending !== PW'(i))
        $display("FAIL queue_fill %0d: pending=%0d, want %0d", i, pending, i);
      else
        checks_passed++;
    end
    event_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_led(1'b0, "queue_fall");
      wait_led(1'b1, "queue_rise");
      checks_total++;
      if (pending !== PW'(exp_p[i]))
        $display("FAIL queue_drain %0d: pending=%0d, want %0d", i, pending, exp_p[i]);
      else
        checks_passed++;
    end
    wait_idle("queue");
    checks_total++;
    if (overflow !== 1'b0)
      $display("FAIL queue_ovf: overflow=%b, want 0", overflow);
    else
      checks_passed++;
  endtask

  task automatic test_overflow();
    int exp_p[5] = '{1, 2, 3, 3, 3};
    int exp_o[5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 4; i++) exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks_total++;
      if (pending !== PW'(exp_p[i]) || overflow !== 1'(exp_o[i]))
        $display("FAIL ovf_fill %0d: pending=%0d ovf=%b, want %0d %0d",
                 i, pending, overflow, exp_p[i], exp_o[i]);
      else
        checks_passed++;
    end
    event_in = 1'b0;
    wait_idle("ovf");
    checks_total++;
    if (overflow !== 1'b1)
      $display("FAIL ovf_sticky: overflow=%b, want 1", overflow);
    else
      checks_passed++;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks_total++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear: overflow=%b, want 0", overflow);
    else
      checks_passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    tick();
    repeat (3) tick();
    event_in = 1'b0;
    wait_led(1'b0, "b2b_fall");
    repeat (OFF_CYC - 1) tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    checks_total++;
    if (led_out !== 1'b1 || pending !== PW'(3) || overflow !== 1'b0)
      $display("FAIL b2b_dequeue: led=%b pending=%0d ovf=%b, want 1 3 0",
               led_out, pending, overflow);
    else
      checks_passed++;
    event_in  = 1'b1;
    clear_ovf = 1'b1;
    tick();
    event_in  = 1'b0;
    clear_ovf = 1'b0;
    checks_total++;
    if (overflow !== 1'b1 || pending !== PW'(3))
      $display("FAIL b2b_set_wins: ovf=%b pending=%0d, want 1 3", overflow, pending);
    else
      checks_passed++;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_mid_reset();
    event_in = 1'b1;
    tick();
    repeat (2) tick();
    event_in = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    checks_total++;
    if ({led_out, busy, pending, overflow} !== '0)
      $display("FAIL midrst_outputs: led=%b busy=%b pending=%0d ovf=%b, want all 0",
               led_out, busy, pending, overflow);
    else
      checks_passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    checks_total++;
    if (led_out !== 1'b1 || pending !== '0)
      $display("FAIL midrst_restart: led=%b pending=%0d, want 1 0", led_out, pending);
    else
      checks_passed++;
    wait_idle("midrst");
  endtask

  task automatic test_held();
    for (int i = 0; i < 4; i++) exp_q.push_back(ON_CYC);
    event_in = 1'b1;
    repeat (10) tick();
    event_in = 1'b0;
    checks_total++;
    if (led_out !== 1'b1 || pending !== PW'(3) || overflow !== 1'b1)
      $display("FAIL held_state: led=%b pending=%0d ovf=%b, want 1 3 1",
               led_out, pending, overflow);
    else
      checks_passed++;
    wait_idle("held");
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_held();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
